// File: rtl/myfilter_pkg.sv
// Shared types and constants for the I2C slave controller.
package myfilter_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam int I2C_ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX       = 3'd3,
    RX_ACK   = 3'd4,
    TX       = 3'd5,
    TX_ACK   = 3'd6
  } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizes the raw SCL/SDA pins and derives SCL edges plus START/STOP.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic s_scl,
  output logic s_sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   prev_scl;
  logic                   prev_sda;

  // Synchronizer chains and one-clk-delayed copies; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= {SYNC_STAGES{1'b1}};
      sda_sync <= {SYNC_STAGES{1'b1}};
      prev_scl <= 1'b1;
      prev_sda <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      prev_scl <= scl_sync[SYNC_STAGES-1];
      prev_sda <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign s_scl     = scl_sync[SYNC_STAGES-1];
  assign s_sda     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = s_scl & ~prev_scl;
  assign scl_fall  = ~s_scl & prev_scl;
  // SDA may only change while SCL is high for START/STOP.
  assign start_det = s_scl & prev_sda & ~s_sda;
  assign stop_det  = s_scl & ~prev_sda & s_sda;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: address match, write receive, read transmit.
// Drives the i2c_omux control pins so SDA is pulled low only when required.
module i2c_slave_ctrl
  import myfilter_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h48,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  input  logic [I2C_BYTE_W-1:0] tx_data_in,
  output logic                  tx_req_out,
  output logic [I2C_BYTE_W-1:0] rx_data_out,
  output logic                  rx_valid_out,
  output logic                  oe_out,
  output logic                  osel_out,
  output logic                  ack_out,
  output logic                  sd_out,
  output logic                  busy_out
);

  logic s_scl, s_sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .s_scl    (s_scl),
    .s_sda    (s_sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  i2c_state_t            state, state_nxt;
  logic [2:0]            bitcnt, bitcnt_nxt;
  logic [I2C_BYTE_W-1:0] shreg, shreg_nxt;
  logic [I2C_BYTE_W-1:0] txsh, txsh_nxt;
  logic                  rw, rw_nxt;
  logic                  mack, mack_nxt;
  logic                  byte_done, byte_done_nxt;
  logic                  oe, oe_nxt;
  logic                  osel, osel_nxt;
  logic                  ack, ack_nxt;
  logic                  sd, sd_nxt;
  logic [I2C_BYTE_W-1:0] rx_data, rx_data_nxt;
  logic                  rx_valid, rx_valid_nxt;
  logic                  tx_req, tx_req_nxt;
  logic                  busy;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      txsh      <= 8'h00;
      rw        <= 1'b0;
      mack      <= I2C_NACK;
      byte_done <= 1'b0;
      oe        <= 1'b0;
      osel      <= 1'b0;
      ack       <= 1'b1;
      sd        <= 1'b1;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bitcnt    <= bitcnt_nxt;
      shreg     <= shreg_nxt;
      txsh      <= txsh_nxt;
      rw        <= rw_nxt;
      mack      <= mack_nxt;
      byte_done <= byte_done_nxt;
      oe        <= oe_nxt;
      osel      <= osel_nxt;
      ack       <= ack_nxt;
      sd        <= sd_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_req    <= tx_req_nxt;
      busy      <= (state_nxt != IDLE);
    end
  end

  // Next-state and output logic; STOP beats START beats SCL edges.
  always_comb begin
    state_nxt     = state;
    bitcnt_nxt    = bitcnt;
    shreg_nxt     = shreg;
    txsh_nxt      = txsh;
    rw_nxt        = rw;
    mack_nxt      = mack;
    byte_done_nxt = byte_done;
    oe_nxt        = oe;
    osel_nxt      = osel;
    ack_nxt       = ack;
    sd_nxt        = sd;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    tx_req_nxt    = 1'b0;

    if (stop_det) begin
      state_nxt     = IDLE;
      oe_nxt        = 1'b0;
      osel_nxt      = 1'b0;
      ack_nxt       = 1'b1;
      sd_nxt        = 1'b1;
      byte_done_nxt = 1'b0;
    end else if (start_det) begin
      // Also covers repeated START: any partial byte is dropped.
      state_nxt     = ADDR;
      bitcnt_nxt    = 3'd0;
      oe_nxt        = 1'b0;
      ack_nxt       = 1'b1;
      byte_done_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          oe_nxt = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shreg_nxt  = {shreg[6:0], s_sda};
            bitcnt_nxt = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              byte_done_nxt = 1'b1;
            end else begin
              byte_done_nxt = byte_done;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            rw_nxt        = shreg[0];
            if (shreg[7:1] == SLAVE_ADDR) begin
              state_nxt = ADDR_ACK;
              oe_nxt    = 1'b1;
              osel_nxt  = 1'b0;
              ack_nxt   = I2C_ACK;
            end else begin
              state_nxt = IDLE;
              oe_nxt    = 1'b0;
            end
          end else begin
            state_nxt = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bitcnt_nxt = 3'd0;
            ack_nxt    = I2C_NACK;
            if (rw) begin
              state_nxt  = TX;
              txsh_nxt   = tx_data_in;
              tx_req_nxt = 1'b1;
              oe_nxt     = 1'b1;
              osel_nxt   = 1'b1;
              sd_nxt     = tx_data_in[7];
            end else begin
              state_nxt = RX;
              oe_nxt    = 1'b0;
            end
          end else begin
            state_nxt = ADDR_ACK;
          end
        end
        RX: begin
          if (scl_rise) begin
            shreg_nxt  = {shreg[6:0], s_sda};
            bitcnt_nxt = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              rx_data_nxt   = {shreg[6:0], s_sda};
              rx_valid_nxt  = 1'b1;
              byte_done_nxt = 1'b1;
            end else begin
              byte_done_nxt = byte_done;
            end
          end else if (scl_fall && byte_done) begin
            byte_done_nxt = 1'b0;
            state_nxt     = RX_ACK;
            oe_nxt        = 1'b1;
            osel_nxt      = 1'b0;
            ack_nxt       = I2C_ACK;
          end else begin
            state_nxt = RX;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            state_nxt  = RX;
            bitcnt_nxt = 3'd0;
            oe_nxt     = 1'b0;
            ack_nxt    = I2C_NACK;
          end else begin
            state_nxt = RX_ACK;
          end
        end
        TX: begin
          // bitcnt counts SCL falls since bit 7 was put on the bus.
          if (scl_fall) begin
            if (bitcnt == 3'd7) begin
              state_nxt  = TX_ACK;
              bitcnt_nxt = 3'd0;
              oe_nxt     = 1'b0;
              mack_nxt   = I2C_NACK;
            end else begin
              txsh_nxt   = {txsh[6:0], 1'b0};
              sd_nxt     = txsh[6];
              bitcnt_nxt = bitcnt + 3'd1;
            end
          end else begin
            state_nxt = TX;
          end
        end
        TX_ACK: begin
          // s_scl is high on a genuine rise; SDA is the master's ack bit.
          if (scl_rise && s_scl) begin
            mack_nxt = s_sda;
          end else if (scl_fall) begin
            if (mack == I2C_ACK) begin
              state_nxt  = TX;
              bitcnt_nxt = 3'd0;
              txsh_nxt   = tx_data_in;
              tx_req_nxt = 1'b1;
              oe_nxt     = 1'b1;
              osel_nxt   = 1'b1;
              sd_nxt     = tx_data_in[7];
            end else begin
              state_nxt = IDLE;
              oe_nxt    = 1'b0;
            end
          end else begin
            state_nxt = TX_ACK;
          end
        end
        default: begin
          state_nxt = IDLE;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  assign tx_req_out   = tx_req;
  assign rx_data_out  = rx_data;
  assign rx_valid_out = rx_valid;
  assign oe_out       = oe;
  assign osel_out     = osel;
  assign ack_out      = ack;
  assign sd_out       = sd;
  assign busy_out     = busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: bench acts as I2C master on an
// open-drain bus modelled together with the i2c_omux pull-down behaviour.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

  localparam time Q = 100ns;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req_out, rx_valid_out, oe_out, osel_out, ack_out, sd_out, busy_out;
  logic [7:0] rx_data_out;
  logic       sda_bus;

  // Slave pulls SDA low when enabled and the selected source is 0.
  assign sda_bus = sda_m & ~(oe_out & (osel_out ? ~sd_out : ~ack_out));

  i2c_slave_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_in      (scl_m),
    .sda_in      (sda_bus),
    .tx_data_in  (tx_data),
    .tx_req_out  (tx_req_out),
    .rx_data_out (rx_data_out),
    .rx_valid_out(rx_valid_out),
    .oe_out      (oe_out),
    .osel_out    (osel_out),
    .ack_out     (ack_out),
    .sd_out      (sd_out),
    .busy_out    (busy_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int tx_cnt   = 0;
  int oe_cnt   = 0;

  // Pulse and activity counters.
  always @(posedge clk) begin
    if (rx_valid_out) rx_cnt++;
    if (tx_req_out)   tx_cnt++;
    if (oe_out)       oe_cnt++;
  end

  logic cap_oe, cap_osel, cap_ack;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cond();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic clock_bit(input logic b, output logic bus_b);
    sda_m = b; #(Q);
    scl_m = 1'b1; #(Q);
    bus_b    = sda_bus;
    cap_oe   = oe_out;
    cap_osel = osel_out;
    cap_ack  = ack_out;
    #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  // Eight data bits then the ack slot (released); returns the ack seen.
  task automatic write_byte(input logic [7:0] d, output logic ack_bus);
    logic dummy;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], dummy);
    clock_bit(1'b1, ack_bus);
  endtask

  // Eight bits with SDA released; ack slot handled by the caller.
  task automatic read_byte(output logic [7:0] d, output logic oe_all, output logic osel_all);
    logic b;
    oe_all = 1'b1; osel_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, b);
      d[i] = b;
      oe_all &= cap_oe;
      osel_all &= cap_osel;
    end
  endtask

  logic       ab, oa, sa, dummy;
  logic [7:0] rb;
  int         base_rx, base_tx, base_oe;

  initial begin
    // Reset state
    #(Q);
    check("rst_oe", oe_out, 1'b0);
    check("rst_osel", osel_out, 1'b0);
    check("rst_ack", ack_out, 1'b1);
    check("rst_sd", sd_out, 1'b1);
    check("rst_rx_data", rx_data_out, 8'h00);
    check("rst_busy", busy_out, 1'b0);
    rst_n = 1'b1;
    #(Q);

    // 1. Write 0x90, 0xA5, STOP
    base_rx = rx_cnt;
    start_cond();
    check("t1_busy_after_start", busy_out, 1'b1);
    write_byte(8'h90, ab);
    check("t1_addr_ack_bus", ab, 1'b0);
    check("t1_addr_ack_oe", cap_oe, 1'b1);
    check("t1_addr_ack_osel", cap_osel, 1'b0);
    check("t1_addr_ack_ack", cap_ack, 1'b0);
    write_byte(8'hA5, ab);
    check("t1_data_ack_bus", ab, 1'b0);
    check("t1_data_ack_oe", cap_oe, 1'b1);
    check("t1_data_ack_osel", cap_osel, 1'b0);
    check("t1_data_ack_ack", cap_ack, 1'b0);
    check("t1_rx_data", rx_data_out, 8'hA5);
    check("t1_rx_pulses", rx_cnt - base_rx, 1);
    stop_cond();
    check("t1_busy_after_stop", busy_out, 1'b0);
    check("t1_oe_after_stop", oe_out, 1'b0);

    // 2. Address 0x49 (byte 0x92) is ignored
    base_rx = rx_cnt; base_oe = oe_cnt;
    start_cond();
    write_byte(8'h92, ab);
    check("t2_no_ack", ab, 1'b1);
    check("t2_busy_mismatch", busy_out, 1'b0);
    write_byte(8'h55, ab);
    check("t2_no_data_ack", ab, 1'b1);
    stop_cond();
    check("t2_oe_never", oe_cnt - base_oe, 0);
    check("t2_no_rx_valid", rx_cnt - base_rx, 0);

    // 3. Read 0x91, tx 0x3C, master NACK
    base_tx = tx_cnt;
    tx_data = 8'h3C;
    start_cond();
    write_byte(8'h91, ab);
    check("t3_addr_ack", ab, 1'b0);
    read_byte(rb, oa, sa);
    check("t3_byte", rb, 8'h3C);
    check("t3_oe_bits", oa, 1'b1);
    check("t3_osel_bits", sa, 1'b1);
    clock_bit(1'b1, dummy);
    check("t3_oe_ack_slot", cap_oe, 1'b0);
    check("t3_busy_after_nack", busy_out, 1'b0);
    check("t3_oe_after_nack", oe_out, 1'b0);
    check("t3_tx_req", tx_cnt - base_tx, 1);
    stop_cond();

    // 4. Read with master ACK, 0x3C then 0xC3, then NACK
    base_tx = tx_cnt;
    tx_data = 8'h3C;
    start_cond();
    write_byte(8'h91, ab);
    check("t4_addr_ack", ab, 1'b0);
    read_byte(rb, oa, sa);
    check("t4_byte0", rb, 8'h3C);
    tx_data = 8'hC3;
    clock_bit(1'b0, dummy);
    check("t4_busy_after_mack", busy_out, 1'b1);
    read_byte(rb, oa, sa);
    check("t4_byte1", rb, 8'hC3);
    check("t4_oe_bits1", oa, 1'b1);
    clock_bit(1'b1, dummy);
    check("t4_tx_req", tx_cnt - base_tx, 2);
    check("t4_busy_end", busy_out, 1'b0);
    stop_cond();

    // 5. Repeated START after 4 bits of an RX byte, then read
    base_rx = rx_cnt;
    tx_data = 8'h5A;
    start_cond();
    write_byte(8'h90, ab);
    check("t5_w_addr_ack", ab, 1'b0);
    clock_bit(1'b1, dummy);
    clock_bit(1'b0, dummy);
    clock_bit(1'b1, dummy);
    clock_bit(1'b0, dummy);
    start_cond();
    write_byte(8'h91, ab);
    check("t5_r_addr_ack", ab, 1'b0);
    read_byte(rb, oa, sa);
    check("t5_byte", rb, 8'h5A);
    clock_bit(1'b1, dummy);
    stop_cond();
    check("t5_no_rx_valid", rx_cnt - base_rx, 0);

    // 6a. STOP mid-TX (during a 1 bit so the master can release SDA)
    tx_data = 8'h3C;
    start_cond();
    write_byte(8'h91, ab);
    check("t6_addr_ack", ab, 1'b0);
    clock_bit(1'b1, dummy);
    clock_bit(1'b1, dummy);
    check("t6_oe_mid_tx", oe_out, 1'b1);
    stop_cond();
    check("t6_oe_after_stop", oe_out, 1'b0);
    check("t6_busy_after_stop", busy_out, 1'b0);

    // 6b. Reset during the ack slot of a write byte
    start_cond();
    write_byte(8'h90, ab);
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, dummy);
    check("t6_oe_before_rst", oe_out, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_oe", oe_out, 1'b0);
    check("t6_rst_ack", ack_out, 1'b1);
    check("t6_rst_osel", osel_out, 1'b0);
    check("t6_rst_sd", sd_out, 1'b1);
    check("t6_rst_busy", busy_out, 1'b0);
    check("t6_rst_rx_data", rx_data_out, 8'h00);
    #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
    rst_n = 1'b1; #(Q);
    base_rx = rx_cnt;
    start_cond();
    write_byte(8'h90, ab);
    check("t6_new_addr_ack", ab, 1'b0);
    write_byte(8'h7E, ab);
    check("t6_new_data_ack", ab, 1'b0);
    check("t6_new_rx_data", rx_data_out, 8'h7E);
    check("t6_new_rx_pulse", rx_cnt - base_rx, 1);
    stop_cond();
    check("t6_new_busy", busy_out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
